quadrant_restore: RTL

Completes the angle-reduction path. It sits between the mod-360 reduction stage and the first-quadrant sin/cos core.

- **Forward direction:** it accepts the reduced integer angle and its quadrant, folds the angle into a reference angle of 0..90° and issues it to the core.
- **Return direction:** it holds each quadrant tag in order and applies the matching sign correction to every sin/cos result the core returns.
- **Output:** corrected IEEE-754 double results, presented to downstream logic over a valid/ready handshake.

---
 rtl/trig_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/quadrant_restore.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// Shared quadrant type, angle constants and sign correction for the sin/cos
// angle-reduction path.
package trig_pkg;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quadrant_e;

   localparam int unsigned DEG_90  = 90;
   localparam int unsigned DEG_180 = 2 * DEG_90;
   localparam int unsigned DEG_360 = 4 * DEG_90;

   // Widest result word handled by sign_correct (IEEE-754 double).
   localparam int unsigned MAX_WIDTH = 64;
   localparam int unsigned SIGN_BIT  = MAX_WIDTH - 1;

   // Optionally flip the sign bit, then clear it when the magnitude is zero so
   // that -0 is never produced.
   function automatic logic [MAX_WIDTH-1:0] sign_correct(
      input logic [MAX_WIDTH-1:0] value,
      input logic                 negate,
      input int unsigned          sign_bit = SIGN_BIT
   );
      logic [MAX_WIDTH-1:0] sign_mask;
      logic [MAX_WIDTH-1:0] mag_mask;
      logic [MAX_WIDTH-1:0] result;
      sign_mask = MAX_WIDTH'(1) << sign_bit;
      mag_mask  = sign_mask - MAX_WIDTH'(1);
      result    = negate ? (value ^ sign_mask) : value;
      if ((value & mag_mask) == '0) begin
         result = result & ~sign_mask;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, power-of-two depth (>= 2).
// Writes when full and reads when empty are ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_fire;
   logic             rd_fire;

   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;
   assign rd_data = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({wr_fire, rd_fire})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/quadrant_restore.sv
// Folds reduced angles into 0..90 degrees for the sin/cos core and restores the
// quadrant signs on the results it returns. DATA_WIDTH must not exceed 64.
module quadrant_restore
   import trig_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned TAG_DEPTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_angle,
   input  logic [1:0]            in_quadrant,
   output logic                  fold_valid,
   input  logic                  core_ready,
   output logic [DATA_WIDTH-1:0] fold_angle,
   input  logic                  res_valid,
   input  logic [DATA_WIDTH-1:0] res_sin,
   input  logic [DATA_WIDTH-1:0] res_cos,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_sin,
   output logic [DATA_WIDTH-1:0] out_cos,
   output logic                  err_range,
   output logic                  err_orphan
);

   localparam int unsigned CW    = $clog2(TAG_DEPTH) + 1;
   localparam int unsigned OUT_W = 2 * DATA_WIDTH;

   logic                  fold_valid_q;
   logic [DATA_WIDTH-1:0] fold_angle_q;
   logic [CW-1:0]         credits_q;
   logic [CW-1:0]         credits_d;
   logic                  err_range_q;
   logic                  err_orphan_q;

   logic                  accept;
   logic                  angle_ok;
   logic                  fold_load;
   logic [DATA_WIDTH-1:0] fold_ref;

   logic [1:0]            tag_head;
   logic                  tag_full;
   logic                  tag_empty;
   logic [CW-1:0]         tag_count;
   quadrant_e             head_quad;
   logic                  neg_sin;
   logic                  neg_cos;

   logic                  out_wr;
   logic                  out_pop;
   logic [OUT_W-1:0]      out_wr_data;
   logic [OUT_W-1:0]      out_rd_data;
   logic                  out_full;
   logic                  out_empty;
   logic [CW-1:0]         out_count;

   // Credits cover the fold register, the tag FIFO and the output FIFO, so the
   // output FIFO always has room for every result the core can return.
   assign in_ready  = reset_n && (!fold_valid_q || core_ready) &&
                      (credits_q < CW'(TAG_DEPTH)) && !tag_full;
   assign accept    = in_valid && in_ready;
   assign angle_ok  = (in_angle <= DATA_WIDTH'(DEG_360));
   assign fold_load = accept && angle_ok;

   always_comb begin
      fold_ref = in_angle;
      unique case (quadrant_e'(in_quadrant))
         Q0: fold_ref = (in_angle == DATA_WIDTH'(DEG_360)) ? '0 : in_angle;
         Q1: fold_ref = DATA_WIDTH'(DEG_180) - in_angle;
         Q2: fold_ref = in_angle - DATA_WIDTH'(DEG_180);
         Q3: fold_ref = DATA_WIDTH'(DEG_360) - in_angle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fold_valid_q <= 1'b0;
         fold_angle_q <= '0;
      end else if (fold_load) begin
         fold_valid_q <= 1'b1;
         fold_angle_q <= fold_ref;
      end else if (core_ready) begin
         fold_valid_q <= 1'b0;
      end
   end

   assign fold_valid = fold_valid_q;
   assign fold_angle = fold_angle_q;

   sync_fifo #(
      .WIDTH (2),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (fold_load),
      .wr_data (in_quadrant),
      .rd_en   (res_valid),
      .rd_data (tag_head),
      .full    (tag_full),
      .empty   (tag_empty),
      .count   (tag_count)
   );

   assign head_quad = quadrant_e'(tag_head);

   always_comb begin
      neg_sin = 1'b0;
      neg_cos = 1'b0;
      unique case (head_quad)
         Q0: ;
         Q1: neg_cos = 1'b1;
         Q2: begin
            neg_sin = 1'b1;
            neg_cos = 1'b1;
         end
         Q3: neg_sin = 1'b1;
      endcase
   end

   assign out_wr      = res_valid && !tag_empty && !out_full;
   assign out_wr_data = {DATA_WIDTH'(sign_correct(MAX_WIDTH'(res_sin), neg_sin, DATA_WIDTH - 1)),
                         DATA_WIDTH'(sign_correct(MAX_WIDTH'(res_cos), neg_cos, DATA_WIDTH - 1))};

   sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (TAG_DEPTH)
   ) u_out_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (out_wr),
      .wr_data (out_wr_data),
      .rd_en   (out_pop),
      .rd_data (out_rd_data),
      .full    (out_full),
      .empty   (out_empty),
      .count   (out_count)
   );

   assign out_valid = !out_empty;
   assign out_pop   = out_valid && out_ready;
   // Storage is not reset, so data is masked to zero while nothing is valid.
   assign out_sin   = out_valid ? out_rd_data[OUT_W-1:DATA_WIDTH] : '0;
   assign out_cos   = out_valid ? out_rd_data[DATA_WIDTH-1:0] : '0;

   always_comb begin
      credits_d = credits_q;
      unique case ({fold_load, out_pop})
         2'b10:   credits_d = credits_q + CW'(1);
         2'b01:   credits_d = credits_q - CW'(1);
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         credits_q    <= '0;
         err_range_q  <= 1'b0;
         err_orphan_q <= 1'b0;
      end else begin
         credits_q    <= credits_d;
         err_range_q  <= err_range_q || (accept && !angle_ok);
         err_orphan_q <= err_orphan_q || (res_valid && tag_empty);
      end
   end

   assign err_range  = err_range_q;
   assign err_orphan = err_orphan_q;

   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (credits_q == tag_count + out_count);
      end
   end

endmodule
